// File: rtl/memory_loader.sv
// memory_loader: 64 x 9 program/data memory for the accumulator CPU, with a
// word-serial valid/ready load port. The host fills the memory after
// ld_start, and the CPU is then released via run. Every flop uses the
// rising edge of clk.
module memory_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          run,
    output logic [AW:0]   ld_count,
    input  logic          READ,
    input  logic          WRITE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DATA,
    output logic [DW-1:0] D,
    output logic          access_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   count_q;
    logic          ready_q;
    logic          run_q;
    logic [DW-1:0] d_q;
    logic          err_q;

    logic [DW-1:0] mem_q [DEPTH];

    logic          accept_s;
    logic          final_s;
    logic          cpu_wr_s;
    logic          cpu_rd_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

    // A restart pulse takes priority over a word offered on the same edge.
    assign accept_s = (state_q == ST_LOAD) && ld_valid && !ld_start;
    // The last address is always the final word, so the pointer never wraps.
    assign final_s  = accept_s && (ld_last || (ptr_q == LAST_PTR));
    // CPU strobes act only in RUN; a write beats a simultaneous read.
    assign cpu_wr_s = (state_q == ST_RUN) && WRITE;
    assign cpu_rd_s = (state_q == ST_RUN) && READ && !WRITE;

    // Single memory write port shared by loader and CPU (never both active).
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = ptr_q;
        mem_wdata_s = ld_data;
        if (accept_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = ptr_q;
            mem_wdata_s = ld_data;
        end else if (cpu_wr_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = A;
            mem_wdata_s = DATA;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array: not reset, so contents survive rst_n and restarts.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Session FSM with registered ld_ready/run and load pointer/counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= {AW{1'b0}};
            count_q <= {(AW + 1){1'b0}};
            ready_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= {AW{1'b0}};
                        count_q <= {(AW + 1){1'b0}};
                        ready_q <= 1'b1;
                        run_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_start) begin
                        ptr_q   <= {AW{1'b0}};
                        count_q <= {(AW + 1){1'b0}};
                        ready_q <= 1'b1;
                        run_q   <= 1'b0;
                    end else if (accept_s) begin
                        count_q <= count_q + CNT_ONE;
                        if (final_s) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b0;
                            run_q   <= 1'b1;
                        end else begin
                            ptr_q   <= ptr_q + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    // Registered CPU read data; holds unless a RUN-mode read is serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= {DW{1'b0}};
        end else if (cpu_rd_s) begin
            d_q <= mem_q[A];
        end else begin
            d_q <= d_q;
        end
    end

    // Sticky flag for CPU strobes seen outside RUN; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((READ || WRITE) && (state_q != ST_RUN)) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign ld_ready   = ready_q;
    assign run        = run_q;
    assign ld_count   = count_q;
    assign D          = d_q;
    assign access_err = err_q;

endmodule

// File: doc/memory_loader.md
# memory_loader

Program/data memory for the 9-bit accumulator CPU, sitting directly upstream of it: it drives the CPU's memory data input and consumes its read strobe, write strobe, address and write data. It adds a word-serial load port with valid/ready handshake, so a host can fill the 64 × 9 memory before the CPU is released through `run`. All logic is on the rising edge. The CPU's negedge-triggered registers therefore sample memory outputs half a cycle after they update.

## Interface
- `DEPTH`, 64: number of memory words; must equal 2^`AW`.
- `AW`, 6: address width.
- `DW`, 9: data word width.

- `clk`  in  1  single clock; every flop uses its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_start`  in  1  one-cycle pulse that starts a load session.
- `ld_valid`  in  1  host word valid.
- `ld_data`  in  `DW`  host word.
- `ld_last`  in  1  marks the final word of a session; qualified by `ld_valid`.
- `ld_ready`  out  1  high while in LOAD.
- `run`  out  1  CPU release; high only in RUN.
- `ld_count`  out  `AW`+1  number of words accepted in the current or last session.
- `READ`  in  1  CPU read strobe.
- `WRITE`  in  1  CPU write strobe.
- `A`  in  `AW`  CPU address.
- `DATA`  in  `DW`  CPU write data.
- `D`  out  `DW`  registered read data to the CPU.
- `access_err`  out  1  sticky flag: CPU strobe seen outside RUN.

## Operation
- **States:** IDLE, LOAD, RUN. Reset enters IDLE.
- **IDLE:** `run`=0, `ld_ready`=0.
  - `ld_start` → LOAD. The load pointer and `ld_count` clear to 0.
- **LOAD:** `ld_ready`=1, `run`=0.
  - Each cycle with `ld_valid`=1 writes `ld_data` to `mem[ptr]`, then increments `ptr` and `ld_count`.
  - A word accepted with `ld_last`=1, or the word at `ptr`=`DEPTH`-1, is the final word. The state moves to RUN on that same edge.
  - `ptr` never wraps. Word `DEPTH` cannot be written.
- **RUN:** `run`=1, `ld_ready`=0.
  - Each edge with `READ`=1 and `WRITE`=0: `D` ← `mem[A]`.
  - Each edge with `WRITE`=1: `mem[A]` ← `DATA`, and `D` holds. Write wins if both strobes are high.
  - With neither strobe high, `D` holds.
- **`ld_start` in LOAD or RUN:** restarts LOAD. `ptr` and `ld_count` clear to 0, and `run` drops on that edge. The restart has priority over a simultaneous `ld_valid`, so that word is not written.
- **Words not loaded:** retain their previous contents. The memory array is not reset.
- **`access_err`:** set when `READ` or `WRITE` is high outside RUN. The access is ignored: no memory write, `D` unchanged. Cleared only by reset.
- **`ld_valid` outside LOAD:** ignored.

## Timing
- **Reset values:** state=IDLE, `ld_ready`=0, `run`=0, `ld_count`=0, `D`=0, `access_err`=0, `ptr`=0.
- **Load throughput:** one word per cycle while `ld_valid` is held. The handshake completes on the edge where `ld_valid` & `ld_ready` are both high.
- **Release after final word:**
  - `ld_ready` falls and `run` rises on the same edge that writes the final word.
  - The CPU's first read of address 0 on the following edge returns the new data.
- **Read latency:** `D` is valid one rising edge after `A`/`READ` are presented, which is a half-cycle before the CPU's negedge capture.
- **Write-then-read of the same address on consecutive edges:** returns the new data. There is no bypass path within a single edge.
- **`rst_n` low mid-session:** asynchronous return to the reset values. Memory contents written so far are kept.

## Test plan
- **Basic load:** reset; pulse `ld_start`; stream 5 words 0x101,0x002,0x1FF,0x040,0x155 with `ld_last` on the fifth.
  - `ld_count`=5 and `run`=1 on the 5th accept edge.
  - RUN reads of A=0..4 return the same values on `D` one edge later.
- **Full load:** stream 64 words, value = index, with no `ld_last`.
  - The state enters RUN on the 64th accept and `ld_count`=64.
  - A 65th `ld_valid` is ignored; `mem[0]` still reads 0.
- **Write/read in RUN:** `WRITE`=1, A=0x3F, DATA=0x0AA, then `READ`=1 with A=0x3F on the next edge → `D`=0x0AA.
  - A cycle with `READ`=`WRITE`=1, A=5, DATA=0x077 writes 0x077 and leaves `D` unchanged.
- **Restart mid-load:** after 3 accepted words, pulse `ld_start` together with `ld_valid` (data 0x1EE).
  - `ld_count`=0 and 0x1EE is not written.
  - The next load writes from address 0.
- **Illegal access:** `READ`=1 in IDLE → `access_err`=1, `D` stays 0.
  - `access_err` stays 1 through a later full load and RUN, until `rst_n` is pulsed low.
- **Async reset:** drop `rst_n` between edges in RUN → `run`=0 and `D`=0 immediately.
  - After release, the state is IDLE and a RUN-mode read (after a 1-word load) of address 2 returns the previously loaded value.
